// File: rtl/write_last_generator_pkg.sv
// -----------------------------------------------------------------------------
// rpc_write_pkg
//
// Shared definitions for the write-direction last-beat generator.
//
// Contents:
//   SplitNone / SplitFirst / SplitSecond : encoding of the controller's
//                                          page-split attribute on a command.
//   DefaultLenWidth                      : default command beat-count width.
//   wr_len_entry_t                       : {len, split} pair recorded per
//                                          pending write command (default
//                                          width view of the FIFO entry).
//   upstream_last_expected()             : whether the upstream burst must
//                                          carry w_last on the final beat of a
//                                          segment with the given split code.
// -----------------------------------------------------------------------------
package rpc_write_pkg;

    localparam logic [1:0] SplitNone   = 2'b00;
    localparam logic [1:0] SplitFirst  = 2'b01;
    localparam logic [1:0] SplitSecond = 2'b10;

    localparam int unsigned DefaultLenWidth = 8;

    typedef struct packed {
        logic [DefaultLenWidth-1:0] len;
        logic [1:0]                 split;
    } wr_len_entry_t;

    // Only the first half of a page-split burst ends before the upstream
    // burst does; every other segment ends together with the upstream last.
    function automatic logic upstream_last_expected(input logic [1:0] split);
        return (split != SplitFirst);
    endfunction

endpackage

// File: rtl/wr_len_fifo.sv
// -----------------------------------------------------------------------------
// wr_len_fifo
//
// Depth-entry synchronous FIFO holding the {len, split} record of each
// pending write command. A pushed entry becomes visible at the head on the
// following cycle (no bypass). A push while full is ignored even when a pop
// happens in the same cycle; a pop while empty is ignored.
//
// Ports:
//   clk_i    in   clock
//   rst_i    in   asynchronous active-high reset (empties the FIFO)
//   push_i   in   write entry_i at the tail
//   pop_i    in   discard the head entry
//   entry_i  in   entry to store
//   head_o   out  entry at the head (meaningful only when ~empty_o)
//   full_o   out  count equals Depth
//   empty_o  out  count equals zero
//   count_o  out  number of stored entries
// -----------------------------------------------------------------------------
module wr_len_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 10,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [Width-1:0] entry_i,
    output logic [Width-1:0] head_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Full is judged on the registered count, so a same-cycle pop cannot
    // make room for a push.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Depth is a power of two, so the pointers wrap by natural overflow.
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the head is qualified by empty_o everywhere.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

endmodule

// File: rtl/write_last_generator.sv
// -----------------------------------------------------------------------------
// write_last_generator
//
// Sits between the AXI write-data front end and the PHY write-data port.
// Every executing write command records its beat length and page-split
// attribute; forwarded write beats are counted against the head record so the
// PHY receives a last beat at the end of each command segment, even when the
// upstream burst was split across a DRAM page into two commands. The upstream
// w_last is checked against the split attribute of each segment.
//
// Ports:
//   clk_i           in   clock
//   rst_i           in   asynchronous active-high reset
//   cmd_valid_i     in   command valid toward the PHY
//   cmd_ready_i     in   command ready from the PHY
//   is_write_i      in   executing command is a write
//   split_req_i     in   00 unsplit, 01 first page segment, 10 second segment
//   cmd_len_i       in   beats-1 of the executing command
//   len_full_o      out  length FIFO full (upstream gates cmd_valid with it)
//   w_valid_i       in   upstream write data valid
//   w_data_i        in   upstream write data
//   w_strb_i        in   upstream strobes
//   w_last_i        in   upstream burst last
//   w_ready_o       out  ready to upstream
//   phy_w_valid_o   out  write data valid to the PHY
//   phy_w_data_o    out  write data to the PHY
//   phy_w_strb_o    out  strobes to the PHY
//   phy_w_last_o    out  per-segment last to the PHY
//   phy_w_ready_i   in   PHY write data ready
//   protocol_err_o  out  single-cycle pulse on an upstream last mismatch
//   overflow_o      out  sticky: a command push was attempted while full
// -----------------------------------------------------------------------------
module write_last_generator
    import rpc_write_pkg::*;
#(
    parameter int unsigned Depth     = 4,
    parameter int unsigned LenWidth  = DefaultLenWidth,
    parameter int unsigned DataWidth = 32,
    localparam int unsigned StrbW    = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    input  logic                 cmd_ready_i,
    input  logic                 is_write_i,
    input  logic [1:0]           split_req_i,
    input  logic [LenWidth-1:0]  cmd_len_i,
    output logic                 len_full_o,
    input  logic                 w_valid_i,
    input  logic [DataWidth-1:0] w_data_i,
    input  logic [StrbW-1:0]     w_strb_i,
    input  logic                 w_last_i,
    output logic                 w_ready_o,
    output logic                 phy_w_valid_o,
    output logic [DataWidth-1:0] phy_w_data_o,
    output logic [StrbW-1:0]     phy_w_strb_o,
    output logic                 phy_w_last_o,
    input  logic                 phy_w_ready_i,
    output logic                 protocol_err_o,
    output logic                 overflow_o
);

    localparam int unsigned EntryW = LenWidth + 2;
    localparam int unsigned CntW   = $clog2(Depth) + 1;

    logic [EntryW-1:0]   fifo_entry;
    logic [EntryW-1:0]   fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CntW-1:0]     fifo_count;
    logic                cmd_push;
    logic                seg_pop;

    logic [LenWidth-1:0] head_len;
    logic [1:0]          head_split;

    logic                beat_acc;
    logic                seg_last;

    logic [LenWidth-1:0] beat_cnt_q, beat_cnt_d;
    logic                overflow_q, overflow_d;

    // Read commands never touch the length FIFO.
    assign cmd_push   = cmd_valid_i & cmd_ready_i & is_write_i;
    assign fifo_entry = {cmd_len_i, split_req_i};

    wr_len_fifo #(
        .Depth (Depth),
        .Width (EntryW)
    ) u_len_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (cmd_push),
        .pop_i   (seg_pop),
        .entry_i (fifo_entry),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign head_len   = fifo_head[EntryW-1:2];
    assign head_split = fifo_head[1:0];

    assign len_full_o = (fifo_count == CntW'(Depth));

    // Without a recorded command there is no segment to count against, so
    // upstream data is held off rather than forwarded blind.
    assign w_ready_o     = phy_w_ready_i & ~fifo_empty;
    assign phy_w_valid_o = w_valid_i & ~fifo_empty;
    assign phy_w_data_o  = w_data_i;
    assign phy_w_strb_o  = w_strb_i;

    assign beat_acc     = w_valid_i & w_ready_o;
    assign seg_last     = (beat_cnt_q == head_len);
    assign phy_w_last_o = ~fifo_empty & seg_last;

    // The final beat of a segment pops before the counter could wrap, which
    // also covers head_len = all-ones.
    assign seg_pop = beat_acc & seg_last;

    // On a segment's final beat the upstream last must match the split code;
    // on any earlier beat an upstream last is always premature.
    assign protocol_err_o = beat_acc &
                            (seg_last ? (w_last_i != upstream_last_expected(head_split))
                                      : w_last_i);

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        overflow_d = overflow_q | (cmd_push & fifo_full);
        if (beat_acc) begin
            beat_cnt_d = seg_last ? '0 : beat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beat_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow_o = overflow_q;

endmodule
